// File: rtl/ysyx_24080014_ifu_fsm.sv
// Multi-cycle instruction fetch unit: issues one read per instruction, hands the word to
// decode, then waits for the jump stage to commit the next PC. Any fault parks the unit until reset.
module ysyx_24080014_ifu_fsm #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        inst_ready,
  input  logic        commit_valid,
  input  logic [31:0] commit_npc,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ACCESS   = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_EXEC,
    S_FAULT
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        pc_nxt;
  logic [31:0]        inst_nxt;
  logic [1:0]         cause_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      inst        <= '0;
      fault_cause <= CAUSE_NONE;
      timer       <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      inst        <= inst_nxt;
      fault_cause <= cause_nxt;
      timer       <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_nxt  = inst;
    cause_nxt = fault_cause;
    timer_nxt = timer;
    case (state)
      // A response seen here belongs to an abandoned transaction and is dropped.
      S_FETCH: begin
        if (req_ready) begin
          state_nxt = S_WAIT;
          timer_nxt = '0;
        end
      end
      // An error response wins over a timeout expiring in the same cycle.
      S_WAIT: begin
        if (rsp_valid) begin
          if (rsp_err) begin
            state_nxt = S_FAULT;
            cause_nxt = CAUSE_ACCESS;
          end else begin
            inst_nxt  = rsp_data;
            state_nxt = S_ISSUE;
          end
        end else if (timer == TIMER_LAST) begin
          state_nxt = S_FAULT;
          cause_nxt = CAUSE_TIMEOUT;
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      S_ISSUE: begin
        if (inst_ready) begin
          state_nxt = S_EXEC;
        end
      end
      // The PC only ever advances from a committed, word-aligned next PC.
      S_EXEC: begin
        if (commit_valid) begin
          if (commit_npc[1:0] == 2'b00) begin
            pc_nxt    = commit_npc;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_FAULT;
            cause_nxt = CAUSE_MISALIGN;
          end
        end
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  assign req_valid  = (state == S_FETCH);
  assign req_addr   = pc;
  assign inst_valid = (state == S_ISSUE);
  assign fault      = (state == S_FAULT);

endmodule

// File: tb/tb_ysyx_24080014_ifu_fsm.sv
// Bench for the fetch FSM: directed vector table, corner-case sequences, and a random run
// checked against a transaction-level model of the fetch/issue/commit protocol.
module tb_ysyx_24080014_ifu_fsm;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          TIMEOUT  = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        rsp_err = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_ready = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_npc = '0;
  logic        fault;
  logic [1:0]  fault_cause;

  int n_vec = 0;
  int n_err = 0;

  ysyx_24080014_ifu_fsm #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .inst_valid(inst_valid), .inst(inst), .pc(pc), .inst_ready(inst_ready),
    .commit_valid(commit_valid), .commit_npc(commit_npc),
    .fault(fault), .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rr, rv, re;
    logic [31:0] rd;
    logic        ir, cv;
    logic [31:0] cn;
    logic        erv, eiv, ef;
    logic [1:0]  ec;
    logic [31:0] epc, einst;
  } vec_t;

  function automatic vec_t mk(input logic rr, rv, re, input logic [31:0] rd,
                              input logic ir, cv, input logic [31:0] cn,
                              input logic erv, eiv, ef, input logic [1:0] ec,
                              input logic [31:0] epc, einst);
    vec_t v;
    v.rr = rr; v.rv = rv; v.re = re; v.rd = rd; v.ir = ir; v.cv = cv; v.cn = cn;
    v.erv = erv; v.eiv = eiv; v.ef = ef; v.ec = ec; v.epc = epc; v.einst = einst;
    return v;
  endfunction

  task automatic chk_out(input string tag, input logic erv, eiv, ef, input logic [1:0] ec,
                         input logic [31:0] epc, einst);
    logic [100:0] act, exp;
    act = {req_valid, inst_valid, fault, fault_cause, req_addr, pc, inst};
    exp = {erv, eiv, ef, ec, epc, epc, einst};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rv=%b iv=%b f=%b c=%b addr=%h pc=%h inst=%h, expected rv=%b iv=%b f=%b c=%b pc=%h inst=%h",
               tag, req_valid, inst_valid, fault, fault_cause, req_addr, pc, inst,
               erv, eiv, ef, ec, epc, einst);
    end
  endtask

  task automatic set_in(input logic rr, rv, re, input logic [31:0] rd,
                        input logic ir, cv, input logic [31:0] cn);
    req_ready = rr; rsp_valid = rv; rsp_err = re; rsp_data = rd;
    inst_ready = ir; commit_valid = cv; commit_npc = cn;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Best-case single instruction: accept, 1-cycle response, immediate issue, immediate commit.
  task automatic one_inst(input logic [31:0] data, input logic [31:0] npc);
    set_in(1, 0, 0, 0, 0, 0, 0);          @(negedge clk);
    set_in(0, 1, 0, data, 0, 0, 0);       @(negedge clk);
    set_in(0, 0, 0, 0, 1, 0, 0);          @(negedge clk);
    set_in(0, 0, 0, 0, 0, 1, npc);        @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference model: protocol phases as flags plus an elapsed-wait count.
  bit          m_req, m_out, m_pres, m_exec, m_fault;
  int          m_wait;
  logic [31:0] m_pc, m_inst;
  logic [1:0]  m_cause;

  task automatic m_reset();
    m_req = 1; m_out = 0; m_pres = 0; m_exec = 0; m_fault = 0;
    m_wait = 0; m_pc = RESET_PC; m_inst = 0; m_cause = 2'b00;
  endtask

  task automatic m_step();
    if (m_fault) return;
    if (m_req) begin
      if (req_ready) begin m_req = 0; m_out = 1; m_wait = 0; end
    end else if (m_out) begin
      if (rsp_valid) begin
        m_out = 0;
        if (rsp_err) begin m_fault = 1; m_cause = 2'b01; end
        else begin m_inst = rsp_data; m_pres = 1; end
      end else begin
        m_wait++;
        if (m_wait == TIMEOUT) begin m_out = 0; m_fault = 1; m_cause = 2'b11; end
      end
    end else if (m_pres) begin
      if (inst_ready) begin m_pres = 0; m_exec = 1; end
    end else if (m_exec) begin
      if (commit_valid) begin
        m_exec = 0;
        if (commit_npc[1:0] == 2'b00) begin m_pc = commit_npc; m_req = 1; end
        else begin m_fault = 1; m_cause = 2'b10; end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[21];
    logic [31:0] tmp;
    int fault_age;

    tbl[0]  = mk(1,0,0,32'h0,       0,0,32'h0,        1,0,0,2'd0,32'h80000000,32'h0);
    tbl[1]  = mk(0,1,0,32'h00000413,0,0,32'h0,        0,0,0,2'd0,32'h80000000,32'h0);
    tbl[2]  = mk(0,0,0,32'h0,       1,0,32'h0,        0,1,0,2'd0,32'h80000000,32'h00000413);
    tbl[3]  = mk(0,0,0,32'h0,       0,1,32'h80000004, 0,0,0,2'd0,32'h80000000,32'h00000413);
    tbl[4]  = mk(0,1,1,32'hffffffff,0,0,32'h0,        1,0,0,2'd0,32'h80000004,32'h00000413);
    tbl[5]  = mk(0,0,0,32'h0,       0,0,32'h0,        1,0,0,2'd0,32'h80000004,32'h00000413);
    tbl[6]  = mk(0,0,0,32'h0,       0,1,32'h12345678, 1,0,0,2'd0,32'h80000004,32'h00000413);
    tbl[7]  = mk(1,0,0,32'h0,       0,0,32'h0,        1,0,0,2'd0,32'h80000004,32'h00000413);
    tbl[8]  = mk(0,0,0,32'h0,       0,1,32'h40000000, 0,0,0,2'd0,32'h80000004,32'h00000413);
    tbl[9]  = mk(0,1,0,32'h00100093,0,0,32'h0,        0,0,0,2'd0,32'h80000004,32'h00000413);
    tbl[10] = mk(0,0,0,32'h0,       0,1,32'h90000000, 0,1,0,2'd0,32'h80000004,32'h00100093);
    tbl[11] = mk(0,0,0,32'h0,       0,0,32'h0,        0,1,0,2'd0,32'h80000004,32'h00100093);
    tbl[12] = mk(0,0,0,32'h0,       1,0,32'h0,        0,1,0,2'd0,32'h80000004,32'h00100093);
    tbl[13] = mk(0,0,0,32'h0,       0,0,32'h0,        0,0,0,2'd0,32'h80000004,32'h00100093);
    tbl[14] = mk(0,0,0,32'h0,       0,1,32'h80000100, 0,0,0,2'd0,32'h80000004,32'h00100093);
    tbl[15] = mk(1,0,0,32'h0,       0,0,32'h0,        1,0,0,2'd0,32'h80000100,32'h00100093);
    tbl[16] = mk(0,1,0,32'h0000006f,0,0,32'h0,        0,0,0,2'd0,32'h80000100,32'h00100093);
    tbl[17] = mk(0,0,0,32'h0,       1,0,32'h0,        0,1,0,2'd0,32'h80000100,32'h0000006f);
    tbl[18] = mk(0,0,0,32'h0,       0,1,32'h80000106, 0,0,0,2'd0,32'h80000100,32'h0000006f);
    tbl[19] = mk(1,1,1,32'h0,       1,1,32'h80000200, 0,0,1,2'd2,32'h80000100,32'h0000006f);
    tbl[20] = mk(1,1,0,32'h1,       1,1,32'h80000200, 0,0,1,2'd2,32'h80000100,32'h0000006f);

    // Reset values, checked while rst is still held
    @(negedge clk);
    @(negedge clk);
    chk_out("reset_hold", 1, 0, 0, 2'd0, RESET_PC, 32'h0);
    rst = 1'b0;

    // Directed table: basic fetch, backpressure, ignored commits/stale rsp, misaligned commit
    for (int i = 0; i < 21; i++) begin
      set_in(tbl[i].rr, tbl[i].rv, tbl[i].re, tbl[i].rd, tbl[i].ir, tbl[i].cv, tbl[i].cn);
      chk_out($sformatf("tbl[%0d]", i), tbl[i].erv, tbl[i].eiv, tbl[i].ef, tbl[i].ec,
              tbl[i].epc, tbl[i].einst);
      @(negedge clk);
    end

    // Access error in WAIT: sticky until reset
    do_reset();
    chk_out("err_fetch", 1, 0, 0, 2'd0, RESET_PC, 32'h0);
    set_in(1, 0, 0, 0, 0, 0, 0);           @(negedge clk);
    set_in(0, 1, 1, 32'hcafef00d, 0, 0, 0); @(negedge clk);
    set_in(1, 1, 0, 32'h13, 1, 1, 32'h80000010);
    for (int k = 0; k < 4; k++) begin
      chk_out($sformatf("err_sticky[%0d]", k), 0, 0, 1, 2'd1, RESET_PC, 32'h0);
      @(negedge clk);
    end
    do_reset();
    chk_out("err_cleared", 1, 0, 0, 2'd0, RESET_PC, 32'h0);

    // Timeout: fault appears exactly TIMEOUT cycles after acceptance
    set_in(1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    set_in(0, 0, 1, 0, 0, 0, 0);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk_out("timeout_before", 0, 0, 0, 2'd0, RESET_PC, 32'h0);
    @(negedge clk);
    chk_out("timeout_hit", 0, 0, 1, 2'd3, RESET_PC, 32'h0);
    @(negedge clk);
    chk_out("timeout_held", 0, 0, 1, 2'd3, RESET_PC, 32'h0);

    // Reset in WAIT, then a stale response after release
    do_reset();
    one_inst(32'h00000413, 32'h80000010);
    chk_out("pre_rst_fetch", 1, 0, 0, 2'd0, 32'h80000010, 32'h00000413);
    set_in(1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 1, 0, 32'hdeadbeef, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      chk_out($sformatf("stale_rsp[%0d]", k), 1, 0, 0, 2'd0, RESET_PC, 32'h0);
      @(negedge clk);
    end
    set_in(1, 0, 0, 0, 0, 0, 0); @(negedge clk);
    set_in(0, 1, 0, 32'h00000013, 0, 0, 0);
    chk_out("refetch_wait", 0, 0, 0, 2'd0, RESET_PC, 32'h0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk_out("refetch_issue", 0, 1, 0, 2'd0, RESET_PC, 32'h00000013);

    // Randomized run against the reference model
    @(negedge clk);
    do_reset();
    m_reset();
    fault_age = 0;
    for (int i = 0; i < 4000; i++) begin
      chk_out($sformatf("rand[%0d]", i), m_req, m_pres, m_fault, m_cause, m_pc, m_inst);
      fault_age = m_fault ? fault_age + 1 : 0;
      if (fault_age > 4) begin
        do_reset();
        m_reset();
        fault_age = 0;
      end else begin
        req_ready    = ($urandom_range(0, 2) != 0);
        rsp_valid    = ($urandom_range(0, 2) == 0);
        rsp_err      = rsp_valid ? ($urandom_range(0, 29) == 0) : 1'($urandom_range(0, 1));
        rsp_data     = $urandom;
        inst_ready   = 1'($urandom_range(0, 1));
        commit_valid = ($urandom_range(0, 2) == 0);
        tmp          = $urandom;
        commit_npc   = ($urandom_range(0, 15) == 0) ? tmp : {tmp[31:2], 2'b00};
        m_step();
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
